// File: rtl/ifetch.sv
// Instruction fetch front end: credit-limited request issue to instruction memory,
// in-order response tracking, a two-entry instruction buffer and redirect flushing.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic {
        BOOT,
        FETCH
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic [31:0] r_fetchPc;
    logic [1:0]  r_outCnt;
    logic [1:0]  r_dropCnt;
    logic [1:0]  r_fifoCnt;
    logic        r_fifoHead;
    logic        r_reqHead;
    logic [31:0] r_fifoPc   [2];
    logic [31:0] r_fifoData [2];
    logic [31:0] r_reqPc    [2];

    logic [2:0]  w_inUse;
    logic        w_reqFire;
    logic        w_rspFire;
    logic        w_rspKeep;
    logic        w_pop;
    logic        w_reqTail;
    logic        w_fifoTail;

    // Credits cover both outstanding requests and buffered instructions, so the buffer cannot overflow.
    assign w_inUse        = {1'b0, r_outCnt} + {1'b0, r_fifoCnt};
    assign imem_req_valid = (r_state == FETCH) && !redirect_valid && (w_inUse < 3'(DEPTH));
    assign imem_addr      = r_fetchPc;

    assign w_reqFire  = imem_req_valid && imem_req_ready;
    assign w_rspFire  = imem_rsp_valid && (r_outCnt != 2'd0);
    assign w_rspKeep  = w_rspFire && (r_dropCnt == 2'd0) && !redirect_valid;
    assign w_pop      = inst_valid && inst_ready;
    assign w_reqTail  = r_reqHead ^ r_outCnt[0];
    assign w_fifoTail = r_fifoHead ^ r_fifoCnt[0];

    assign inst_valid = (r_fifoCnt != 2'd0);
    assign inst       = inst_valid ? r_fifoData[r_fifoHead] : 32'h0;
    assign inst_pc    = inst_valid ? r_fifoPc[r_fifoHead]   : 32'h0;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            BOOT:    w_stateNext = FETCH;
            FETCH:   w_stateNext = FETCH;
            default: w_stateNext = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchPc  <= RESET_PC;
            r_outCnt   <= 2'd0;
            r_dropCnt  <= 2'd0;
            r_fifoCnt  <= 2'd0;
            r_fifoHead <= 1'b0;
            r_reqHead  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifoPc[i]   <= 32'h0;
                r_fifoData[i] <= 32'h0;
                r_reqPc[i]    <= 32'h0;
            end
        end else begin
            if (w_reqFire) begin
                r_reqPc[w_reqTail] <= r_fetchPc;
            end
            if (w_rspFire) begin
                r_reqHead <= ~r_reqHead;
            end
            r_outCnt <= r_outCnt + {1'b0, w_reqFire} - {1'b0, w_rspFire};

            if (redirect_valid) begin
                r_fetchPc <= redirect_pc;
            end else if (w_reqFire) begin
                r_fetchPc <= r_fetchPc + 32'd1;
            end

            // Everything still outstanding after this cycle's response belongs to the old path.
            if (redirect_valid) begin
                r_dropCnt <= r_outCnt - {1'b0, w_rspFire};
            end else if (w_rspFire && (r_dropCnt != 2'd0)) begin
                r_dropCnt <= r_dropCnt - 2'd1;
            end

            if (redirect_valid) begin
                r_fifoCnt  <= 2'd0;
                r_fifoHead <= 1'b0;
            end else begin
                if (w_rspKeep) begin
                    r_fifoPc[w_fifoTail]   <= r_reqPc[r_reqHead];
                    r_fifoData[w_fifoTail] <= imem_rsp_data;
                end
                if (w_pop) begin
                    r_fifoHead <= ~r_fifoHead;
                end
                r_fifoCnt <= r_fifoCnt + {1'b0, w_rspKeep} - {1'b0, w_pop};
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: a queue-based reference model plus a simple
// in-order instruction memory, driven by directed scenarios and random traffic.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ifetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: pcs of requests in flight (with a "discard" mark) and the buffered instructions.
    bit          mBoot;
    logic [31:0] mFetchPc;
    logic [31:0] mReqPc[$];
    bit          mReqDrop[$];
    logic [31:0] mFifoPc[$];
    logic [31:0] mFifoData[$];

    // Memory environment: accepted addresses with the cycle their response becomes due.
    logic [31:0] memAddr[$];
    int          memDue[$];
    int          cyc = 0;
    int          lastDue = 0;
    int          memMaxLat = 1;
    bit          memHold = 1'b0;
    bit          dutAccept = 1'b0;
    logic [31:0] dutAddr = 32'h0;
    int          acceptCount = 0;
    logic [31:0] dutDelivered[$];

    bit          randMode = 1'b0;
    bit          dIReady = 1'b0;
    bit          dInstReady = 1'b0;
    bit          dRv = 1'b0;
    logic [31:0] dRpc = 32'h0;

    function automatic logic [31:0] dataOf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelReqValid();
        return !mBoot && !redirect_valid && ((mReqPc.size() + mFifoPc.size()) < 2);
    endfunction

    task automatic modelReset();
        mBoot    = 1'b1;
        mFetchPc = RESET_PC;
        mReqPc.delete();
        mReqDrop.delete();
        mFifoPc.delete();
        mFifoData.delete();
    endtask

    task automatic modelUpdate();
        bit          reqFire;
        bit          rspFire;
        bit          keep;
        logic [31:0] kpc;
        reqFire = modelReqValid() && imem_req_ready;
        rspFire = imem_rsp_valid && (mReqPc.size() > 0);
        keep    = 1'b0;
        kpc     = 32'h0;
        if (rspFire) begin
            kpc  = mReqPc.pop_front();
            keep = !mReqDrop.pop_front() && !redirect_valid;
        end
        if (inst_ready && (mFifoPc.size() > 0)) begin
            void'(mFifoPc.pop_front());
            void'(mFifoData.pop_front());
        end
        if (redirect_valid) begin
            mFifoPc.delete();
            mFifoData.delete();
            foreach (mReqDrop[i]) mReqDrop[i] = 1'b1;
            mFetchPc = redirect_pc;
        end
        if (keep) begin
            mFifoPc.push_back(kpc);
            mFifoData.push_back(imem_rsp_data);
        end
        if (reqFire) begin
            mReqPc.push_back(mFetchPc);
            mReqDrop.push_back(1'b0);
            mFetchPc = mFetchPc + 32'd1;
        end
        mBoot = 1'b0;
    endtask

    task automatic memUpdate();
        int d;
        cyc++;
        if (imem_rsp_valid) begin
            void'(memAddr.pop_front());
            void'(memDue.pop_front());
        end
        if (dutAccept) begin
            d = cyc + int'($urandom_range(0, memMaxLat - 1));
            if (d < lastDue) d = lastDue;
            memAddr.push_back(dutAddr);
            memDue.push_back(d);
            lastDue = d;
            acceptCount++;
        end
    endtask

    task automatic applyStimulus();
        if (randMode) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 4) < 3);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFFFFFF - $urandom_range(0, 3));
        end else begin
            imem_req_ready = dIReady;
            inst_ready     = dInstReady;
            redirect_valid = dRv;
            redirect_pc    = dRpc;
        end
        imem_rsp_valid = !memHold && (memAddr.size() > 0) && (memDue[0] <= cyc);
        imem_rsp_data  = imem_rsp_valid ? dataOf(memAddr[0]) : $urandom;
    endtask

    task automatic checkOutput();
        bit expReq;
        expReq = modelReqValid();
        check("req_valid", 32'(imem_req_valid), 32'(expReq));
        check("imem_addr", imem_addr, mFetchPc);
        check("inst_valid", 32'(inst_valid), 32'(mFifoPc.size() > 0));
        if (mFifoPc.size() > 0) begin
            check("inst", inst, mFifoData[0]);
            check("inst_pc", inst_pc, mFifoPc[0]);
        end
        dutAccept = imem_req_valid && imem_req_ready;
        dutAddr   = imem_addr;
        if (inst_valid && inst_ready) dutDelivered.push_back(inst_pc);
    endtask

    task automatic runCycle();
        @(posedge clk);
        modelUpdate();
        memUpdate();
        #1;
        applyStimulus();
        @(negedge clk);
        checkOutput();
    endtask

    // Reset asserted away from any clock edge; outputs must fall without waiting for a clock.
    task automatic resetDut();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        modelReset();
        memAddr.delete();
        memDue.delete();
        lastDue     = cyc;
        acceptCount = 0;
        dutAccept   = 1'b0;
        dutDelivered.delete();
        @(negedge clk);
        applyStimulus();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput();
        check("boot_no_req", 32'(imem_req_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Sustained fetch with a one-cycle memory and an always-ready decoder.
        randMode = 1'b0; dIReady = 1'b1; dInstReady = 1'b1; dRv = 1'b0; memMaxLat = 1; memHold = 1'b0;
        resetDut();
        for (int i = 0; i < 12; i++) runCycle();
        for (int i = 0; i < 3; i++)
            check("seq_pc", (dutDelivered.size() > i) ? dutDelivered[i] : 32'hDEADBEEF, 32'(i));

        // Decoder stalled: exactly two requests, then the credit is exhausted.
        dInstReady = 1'b0;
        resetDut();
        for (int i = 0; i < 8; i++) runCycle();
        check("stall_accepts", 32'(acceptCount), 32'd2);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_inst_pc", inst_pc, 32'h0);
        dInstReady = 1'b1;
        runCycle();
        dInstReady = 1'b0;
        runCycle();
        check("stall_next_valid", 32'(imem_req_valid), 32'd1);
        check("stall_next_addr", imem_addr, 32'h2);

        // Redirect during boot to the top word, memory not ready, then address wrap.
        dIReady = 1'b0; dInstReady = 1'b1; dRv = 1'b1; dRpc = 32'hFFFFFFFF;
        resetDut();
        dRv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            runCycle();
            check("hold_addr", imem_addr, 32'hFFFFFFFF);
        end
        dIReady = 1'b1;
        runCycle();
        runCycle();
        check("wrap_addr", imem_addr, 32'h0);
        for (int i = 0; i < 6; i++) runCycle();

        // Redirect with two responses still outstanding: both are discarded.
        dIReady = 1'b1; dInstReady = 1'b1; dRv = 1'b0; memHold = 1'b1;
        resetDut();
        for (int i = 0; i < 3; i++) runCycle();
        check("two_outstanding", 32'(acceptCount), 32'd2);
        dRv = 1'b1; dRpc = 32'h40;
        runCycle();
        dRv = 1'b0; memHold = 1'b0;
        for (int i = 0; i < 8; i++) runCycle();
        check("redirect_first", (dutDelivered.size() > 0) ? dutDelivered[0] : 32'hDEADBEEF, 32'h40);

        // Random traffic with variable memory latency and frequent redirects.
        memMaxLat = 3;
        randMode  = 1'b1;
        resetDut();
        for (int i = 0; i < 3000; i++) runCycle();

        // Fill the buffer with nothing in flight, then reset asynchronously.
        randMode = 1'b0; dIReady = 1'b1; dInstReady = 1'b0; dRv = 1'b0;
        for (int i = 0; i < 8; i++) runCycle();
        check("full_inst_valid", 32'(inst_valid), 32'd1);
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        memMaxLat = 1;
        resetDut();
        runCycle();
        check("post_reset_valid", 32'(imem_req_valid), 32'd1);
        check("post_reset_addr", imem_addr, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
